// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard unit for the 5-stage pipeline.
// Shadows the destination registers of the instructions in EX and MEM.
// Produces registered EX-stage forward selects, load-use stall/bubble, MUL hold and a stall counter.
// The WB slot is not stored: the regfile is write-first, so nothing here ever reads it.
module fwd_hazard_scoreboard #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_reg_write,
    input  logic                        id_is_load,
    input  logic                        id_is_mul,
    input  logic                        flush,
    output logic [NUM_SRC*2-1:0]        fwd_sel,
    output logic                        stall_id,
    output logic                        bubble_ex,
    output logic                        hold_ex,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int unsigned FWD_W  = NUM_SRC * 2;
    localparam int unsigned BUSY_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [BUSY_W-1:0] MUL_HOLD = BUSY_W'(MUL_LAT - 1);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              load;
        logic [REG_AW-1:0] rd;
    } ex_slot_t;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [REG_AW-1:0] rd;
    } mem_slot_t;

    ex_slot_t          ex_q,        ex_d;
    mem_slot_t         mem_q,       mem_d;
    logic [BUSY_W-1:0] busy_q,      busy_d;
    logic [FWD_W-1:0]  fwd_sel_q,   fwd_sel_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [FWD_W-1:0]  fwd_calc_c;
    logic              load_use_c;

    // Match each used ID operand against the EX and MEM shadow slots.
    always_comb begin : operand_match
        logic [REG_AW-1:0] src;
        logic              ex_hit;
        logic              mem_hit;
        src        = '0;
        ex_hit     = 1'b0;
        mem_hit    = 1'b0;
        fwd_calc_c = '0;
        load_use_c = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src     = id_src[k*REG_AW +: REG_AW];
            ex_hit  = ex_q.valid & ex_q.wr & (ex_q.rd == src) & (src != '0);
            mem_hit = mem_q.valid & mem_q.wr & (mem_q.rd == src) & (src != '0);
            if (id_valid && id_src_used[k]) begin
                if (ex_hit) begin
                    fwd_calc_c[k*2 +: 2] = FWD_EXMEM;
                end else if (mem_hit) begin
                    fwd_calc_c[k*2 +: 2] = FWD_MEMWB;
                end else begin
                    fwd_calc_c[k*2 +: 2] = FWD_RF;
                end
                if (ex_q.load && ex_hit) begin
                    load_use_c = 1'b1;
                end
            end
        end
    end

    assign hold_ex   = (busy_q != '0);
    assign bubble_ex = load_use_c & ~hold_ex;
    assign stall_id  = hold_ex | load_use_c;
    assign fwd_sel   = fwd_sel_q;
    assign stall_cnt = stall_cnt_q;

    // Shadow pipeline advance: flush beats MUL hold beats load-use bubble beats normal issue.
    always_comb begin : next_state
        ex_d        = ex_q;
        mem_d       = mem_q;
        busy_d      = busy_q;
        fwd_sel_d   = fwd_sel_q;
        stall_cnt_d = stall_cnt_q;

        if (stall_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            // The instruction already in EX still retires; ID and EX are squashed.
            ex_d      = '0;
            mem_d     = '{valid: ex_q.valid, wr: ex_q.wr, rd: ex_q.rd};
            busy_d    = '0;
            fwd_sel_d = '0;
        end else if (hold_ex) begin
            // MUL keeps EX and its already-latched operands; MEM sees NOPs meanwhile.
            mem_d  = '0;
            busy_d = busy_q - BUSY_W'(1);
        end else if (bubble_ex) begin
            ex_d      = '0;
            mem_d     = '{valid: ex_q.valid, wr: ex_q.wr, rd: ex_q.rd};
            fwd_sel_d = fwd_calc_c;
        end else begin
            mem_d     = '{valid: ex_q.valid, wr: ex_q.wr, rd: ex_q.rd};
            fwd_sel_d = fwd_calc_c;
            busy_d    = '0;
            if (id_valid) begin
                ex_d = '{valid: 1'b1, wr: id_reg_write, load: id_is_load, rd: id_rd};
                if (id_is_mul) begin
                    busy_d = MUL_HOLD;
                end
            end else begin
                ex_d = '0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            busy_q      <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            busy_q      <= busy_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard.
// Three instances share one stimulus stream: MUL_LAT=3, MUL_LAT=1, and MUL_LAT=3 with a 2-bit counter.
// Each instance has its own instruction-level reference model (EX/MEM instruction records plus EX age).
module tb_fwd_hazard_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       id_is_mul;
    logic       flush;

    logic [3:0]  fwd_w   [3];
    logic        stall_w [3];
    logic        bub_w   [3];
    logic        hold_w  [3];
    logic [15:0] cnt_w0;
    logic [15:0] cnt_w1;
    logic [1:0]  cnt_w2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        bit       v;
        bit       wr;
        bit       ld;
        bit       mul;
        bit [4:0] rd;
        bit [3:0] fwd;
    } ins_t;

    ins_t  m_ex   [3];
    ins_t  m_mem  [3];
    int    m_age  [3];
    int    m_cnt  [3];
    bit    m_fwd_zero [3];
    bit    m_took0;
    int    lat  [3] = '{3, 1, 3};
    int    cmax [3] = '{65535, 65535, 3};

    fwd_hazard_scoreboard #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(3), .CNT_W(16)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
        .flush(flush), .fwd_sel(fwd_w[0]), .stall_id(stall_w[0]), .bubble_ex(bub_w[0]),
        .hold_ex(hold_w[0]), .stall_cnt(cnt_w0)
    );

    fwd_hazard_scoreboard #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(1), .CNT_W(16)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
        .flush(flush), .fwd_sel(fwd_w[1]), .stall_id(stall_w[1]), .bubble_ex(bub_w[1]),
        .hold_ex(hold_w[1]), .stall_cnt(cnt_w1)
    );

    fwd_hazard_scoreboard #(.REG_AW(5), .NUM_SRC(2), .MUL_LAT(3), .CNT_W(2)) u_dut_cnt2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
        .flush(flush), .fwd_sel(fwd_w[2]), .stall_id(stall_w[2]), .bubble_ex(bub_w[2]),
        .hold_ex(hold_w[2]), .stall_cnt(cnt_w2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_cnt(input int c);
        case (c)
            0:       return 32'(cnt_w0);
            1:       return 32'(cnt_w1);
            default: return 32'(cnt_w2);
        endcase
    endfunction

    // An instruction record "writes r" when it is real, writes, targets r, and r is not x0.
    function automatic bit writes(input ins_t s, input logic [4:0] r);
        return s.v && s.wr && (s.rd == r) && (r != 5'd0);
    endfunction

    // A MUL is held until it has spent MUL_LAT cycles in EX.
    function automatic bit m_hold(input int c);
        return m_ex[c].v && m_ex[c].mul && (m_age[c] < lat[c] - 1);
    endfunction

    function automatic bit m_lu(input int c);
        bit lu = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (id_valid && id_src_used[k] && m_ex[c].ld && writes(m_ex[c], id_src[k*5 +: 5]))
                lu = 1'b1;
        end
        return lu;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < 3; c++) begin
            m_ex[c] = '0; m_mem[c] = '0; m_age[c] = 0; m_cnt[c] = 0; m_fwd_zero[c] = 1'b1;
        end
        m_took0 = 1'b0;
    endtask

    // Advance one model instance across a clock edge using the pre-edge inputs.
    task automatic m_edge(input int c);
        bit   h;
        bit   lu;
        ins_t n;
        h  = m_hold(c);
        lu = m_lu(c);
        if ((h || lu) && m_cnt[c] < cmax[c]) m_cnt[c]++;
        m_fwd_zero[c] = 1'b0;
        if (c == 0) m_took0 = flush || !(h || lu);
        if (flush) begin
            m_mem[c] = m_ex[c]; m_ex[c] = '0; m_fwd_zero[c] = 1'b1;
        end else if (h) begin
            m_mem[c] = '0; m_age[c]++;
        end else if (lu) begin
            m_mem[c] = m_ex[c]; m_ex[c] = '0;
        end else begin
            n = '0;
            if (id_valid) begin
                n.v = 1'b1; n.wr = id_reg_write; n.ld = id_is_load; n.mul = id_is_mul; n.rd = id_rd;
                for (int k = 0; k < 2; k++) begin
                    if (id_src_used[k]) begin
                        if (writes(m_ex[c], id_src[k*5 +: 5]))       n.fwd[k*2 +: 2] = 2'b10;
                        else if (writes(m_mem[c], id_src[k*5 +: 5])) n.fwd[k*2 +: 2] = 2'b01;
                    end
                end
            end
            m_mem[c] = m_ex[c]; m_ex[c] = n; m_age[c] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit h;
        bit lu;
        for (int c = 0; c < 3; c++) begin
            h  = m_hold(c);
            lu = m_lu(c);
            chk($sformatf("hold_ex[%0d]", c),   32'(hold_w[c]),  32'(h));
            chk($sformatf("stall_id[%0d]", c),  32'(stall_w[c]), 32'(h || lu));
            chk($sformatf("bubble_ex[%0d]", c), 32'(bub_w[c]),   32'(lu && !h));
            chk($sformatf("stall_cnt[%0d]", c), get_cnt(c),      32'(m_cnt[c]));
            if (m_ex[c].v)          chk($sformatf("fwd_sel[%0d]", c), 32'(fwd_w[c]), 32'(m_ex[c].fwd));
            else if (m_fwd_zero[c]) chk($sformatf("fwd_zero[%0d]", c), 32'(fwd_w[c]), 32'd0);
        end
    endtask

    task automatic drive(input bit v, input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] used,
                         input bit [4:0] rd, input bit wr, input bit ld, input bit mul, input bit fl);
        id_valid = v; id_src = {s1, s0}; id_src_used = used; id_rd = rd;
        id_reg_write = wr; id_is_load = ld; id_is_mul = mul; flush = fl;
    endtask

    // One cycle: check at negedge+1, update models at the posedge, return at the next negedge.
    task automatic step();
        #1 check_all();
        @(posedge clk);
        for (int c = 0; c < 3; c++) m_edge(c);
        @(negedge clk);
    endtask

    // Present an instruction and keep it in ID until the MUL_LAT=3 instance accepts it.
    task automatic issue(input bit v, input bit [4:0] s0, input bit [4:0] s1, input bit [1:0] used,
                         input bit [4:0] rd, input bit wr, input bit ld, input bit mul, output int cyc);
        drive(v, s0, s1, used, rd, wr, ld, mul, 1'b0);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!m_took0 && cyc < 8);
        if (!m_took0) begin
            n_cmp++; n_err++;
            $error("FAIL issue_timeout observed=%0d cycles expected=accepted", cyc);
        end
    endtask

    initial begin
        int cyc;
        bit v, wr, ld, mul;
        int kind;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_fwd", 32'(fwd_w[0]), 32'd0);
        chk("rst_cnt", get_cnt(0), 32'd0);
        chk("rst_stall", 32'(stall_w[0]), 32'd0);
        chk("rst_hold", 32'(hold_w[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // EX/MEM forward for an immediate dependency.
        issue(1, 1, 2, 2'b11, 3, 1, 0, 0, cyc);
        issue(1, 3, 1, 2'b11, 4, 1, 0, 0, cyc);
        chk("t1_fwd", 32'(fwd_w[0]), 32'h2);
        chk("t1_cycles", 32'(cyc), 32'd1);

        // Load-use: one bubble, then MEM/WB forward.
        issue(1, 1, 0, 2'b01, 5, 1, 1, 0, cyc);
        issue(1, 5, 0, 2'b01, 6, 1, 0, 0, cyc);
        chk("t2_cycles", 32'(cyc), 32'd2);
        chk("t2_fwd", 32'(fwd_w[0]), 32'h1);
        chk("t2_cnt", get_cnt(0), 32'd1);

        // x0 never forwards or stalls.
        issue(1, 1, 2, 2'b11, 0, 1, 0, 0, cyc);
        issue(1, 0, 0, 2'b11, 8, 1, 0, 0, cyc);
        chk("t3_fwd", 32'(fwd_w[0]), 32'h0);
        issue(1, 1, 0, 2'b01, 0, 1, 1, 0, cyc);
        issue(1, 0, 0, 2'b11, 9, 1, 0, 0, cyc);
        chk("t3_ld_cycles", 32'(cyc), 32'd1);

        // EX/MEM priority over MEM/WB on both operands.
        issue(1, 1, 2, 2'b11, 7, 1, 0, 0, cyc);
        issue(1, 1, 2, 2'b11, 7, 1, 0, 0, cyc);
        issue(1, 7, 7, 2'b11, 10, 1, 0, 0, cyc);
        chk("t4_fwd", 32'(fwd_w[0]), 32'ha);

        // MUL hold: two hold cycles with MEM NOP'd, consumer gets EX/MEM, older producer not seen.
        issue(1, 1, 2, 2'b11, 12, 1, 0, 0, cyc);
        issue(1, 1, 2, 2'b11, 4, 1, 0, 1, cyc);
        issue(1, 4, 12, 2'b11, 13, 1, 0, 0, cyc);
        chk("t5_cycles", 32'(cyc), 32'd3);
        chk("t5_fwd", 32'(fwd_w[0]), 32'h2);
        chk("t5_cnt", get_cnt(0), 32'd3);
        chk("t5_cnt_lat1", get_cnt(1), 32'd1);

        // Flush during the first hold cycle.
        issue(1, 1, 2, 2'b11, 4, 1, 0, 1, cyc);
        drive(1, 4, 0, 2'b01, 14, 1, 0, 0, 1);
        step();
        chk("t6_flush_hold", 32'(hold_w[0]), 32'd0);
        chk("t6_flush_fwd", 32'(fwd_w[0]), 32'd0);
        issue(0, 0, 0, 0, 0, 0, 0, 0, cyc);

        // Asynchronous reset in the middle of a MUL hold.
        issue(1, 1, 2, 2'b11, 4, 1, 0, 1, cyc);
        drive(1, 4, 0, 2'b01, 15, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_hold", 32'(hold_w[0]), 32'd0);
        chk("t6_rst_stall", 32'(stall_w[0]), 32'd0);
        chk("t6_rst_fwd", 32'(fwd_w[0]), 32'd0);
        chk("t6_rst_cnt", get_cnt(0), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Six MUL stalls: the 2-bit counter saturates at 3.
        for (int i = 0; i < 3; i++) begin
            issue(1, 1, 2, 2'b11, 4, 1, 0, 1, cyc);
            issue(1, 4, 0, 2'b01, 5, 1, 0, 0, cyc);
        end
        chk("t6_sat_cnt2", get_cnt(2), 32'd3);
        chk("t6_cnt16", get_cnt(0), 32'd6);

        // Random traffic against the reference models.
        for (int i = 0; i < 300; i++) begin
            v    = ($urandom_range(0, 9) != 0);
            wr   = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 9);
            ld   = (kind < 3);
            mul  = (kind == 3);
            if ($urandom_range(0, 19) == 0) begin
                drive(v, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 7)), wr, ld, mul, 1'b1);
                step();
            end else begin
                issue(v, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      5'($urandom_range(0, 7)), wr, ld, mul, cyc);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
